// File: rtl/eigen_deflation_ctrl.sv
// Eigen deflation controller: drives an external eigen engine once per
// component, captures each eigenpair and chains the engine's deflated
// matrix back in as the working matrix for the next extraction.
module eigen_deflation_ctrl #(
    parameter int SIZE_N      = 8,
    parameter int NUM_COMP    = 4,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [SIZE_N-1:0][SIZE_N-1:0][63:0]   cov_matrix,
    output logic                                  eig_start,
    output logic [SIZE_N-1:0][SIZE_N-1:0][63:0]   eig_matrix,
    input  logic [0:0][0:0][63:0]                 eig_value,
    input  logic [SIZE_N-1:0][0:0][63:0]          eig_vector,
    input  logic [SIZE_N-1:0][SIZE_N-1:0][63:0]   eig_matrix_out,
    input  logic                                  eig_valid,
    output logic [NUM_COMP-1:0][63:0]             eigenvalues,
    output logic [SIZE_N-1:0][NUM_COMP-1:0][63:0] eigenvectors,
    output logic [$clog2(NUM_COMP+1)-1:0]         comp_count,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  timeout_err
);

    localparam int CW = $clog2(NUM_COMP + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        CAPTURE,
        GAP,
        FINISH
    } state_t;

    state_t                              state;
    state_t                              next_state;
    logic [WW-1:0]                       wd_count;
    logic                                gap_count;
    logic [SIZE_N-1:0][SIZE_N-1:0][63:0] work_matrix;
    logic                                wd_expired;

    // The watchdog expires on the last RUN cycle it allows, so a valid
    // arriving on that same cycle still wins over the timeout.
    assign wd_expired = (wd_count == WW'(TIMEOUT_CYC - 1));

    // The engine always sees the working matrix; data is only moved, never computed.
    assign eig_matrix = work_matrix;

    // State register; reset drops straight to IDLE so eig_start falls at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; eig_start, busy and done are pure functions of state.
    always_comb begin
        next_state = state;
        eig_start  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                eig_start = 1'b1;
                if (eig_valid) begin
                    next_state = CAPTURE;
                end else if (wd_expired) begin
                    next_state = FINISH;
                end
            end
            CAPTURE: begin
                eig_start  = 1'b1;
                next_state = GAP;
            end
            GAP: begin
                if (gap_count) begin
                    next_state = (comp_count == CW'(NUM_COMP)) ? FINISH : RUN;
                end
            end
            FINISH: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: latch on start, watchdog and gap timing, eigenpair capture and deflation chaining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_matrix  <= '0;
            eigenvalues  <= '0;
            eigenvectors <= '0;
            comp_count   <= '0;
            timeout_err  <= 1'b0;
            wd_count     <= '0;
            gap_count    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work_matrix  <= cov_matrix;
                        eigenvalues  <= '0;
                        eigenvectors <= '0;
                        comp_count   <= '0;
                        timeout_err  <= 1'b0;
                        wd_count     <= '0;
                    end
                end
                RUN: begin
                    wd_count <= wd_count + WW'(1);
                    if (!eig_valid && wd_expired) begin
                        timeout_err <= 1'b1;
                    end
                end
                CAPTURE: begin
                    for (int k = 0; k < NUM_COMP; k++) begin
                        if (comp_count == CW'(k)) begin
                            eigenvalues[k] <= eig_value[0][0];
                            for (int i = 0; i < SIZE_N; i++) begin
                                eigenvectors[i][k] <= eig_vector[i][0];
                            end
                        end
                    end
                    work_matrix <= eig_matrix_out;
                    comp_count  <= comp_count + CW'(1);
                    wd_count    <= '0;
                    gap_count   <= 1'b0;
                end
                GAP: begin
                    gap_count <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eigen_deflation_ctrl.sv
// Scoreboard bench for eigen_deflation_ctrl with a stub eigen engine.
module tb_eigen_deflation_ctrl;

    localparam int N  = 8;
    localparam int NC = 4;
    localparam int TO = 50;
    localparam int CW = $clog2(NC + 1);

    typedef logic [N-1:0][N-1:0][63:0] mat_t;
    typedef struct {
        mat_t mat;
        int   len;
    } run_t;
    typedef struct {
        int                         count;
        bit                         terr;
        logic [NC-1:0][63:0]        vals;
        logic [N-1:0][NC-1:0][63:0] vecs;
    } res_t;

    logic                       clk;
    logic                       rst;
    logic                       start;
    mat_t                       cov_matrix;
    logic                       eig_start;
    mat_t                       eig_matrix;
    logic [0:0][0:0][63:0]      eig_value;
    logic [N-1:0][0:0][63:0]    eig_vector;
    mat_t                       eig_matrix_out;
    logic                       eig_valid;
    logic [NC-1:0][63:0]        eigenvalues;
    logic [N-1:0][NC-1:0][63:0] eigenvectors;
    logic [CW-1:0]              comp_count;
    logic                       busy;
    logic                       done;
    logic                       timeout_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    run_t mat_q[$];
    res_t exp_q[$];
    int   last_count = 0;

    int   stub_delay = 10;
    int   stub_cnt   = 0;
    int   stub_k     = 0;
    logic start_d    = 1'b0;

    bit   mon_prev_es   = 0;
    bit   mon_prev_done = 0;
    bit   mon_gap_act   = 0;
    bit   mon_cur_ok    = 0;
    int   mon_hi_len    = 0;
    int   mon_gap_cnt   = 0;
    run_t mon_cur;
    res_t mon_res;

    eigen_deflation_ctrl #(
        .SIZE_N(N),
        .NUM_COMP(NC),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cov_matrix(cov_matrix),
        .eig_start(eig_start),
        .eig_matrix(eig_matrix),
        .eig_value(eig_value),
        .eig_vector(eig_vector),
        .eig_matrix_out(eig_matrix_out),
        .eig_valid(eig_valid),
        .eigenvalues(eigenvalues),
        .eigenvectors(eigenvectors),
        .comp_count(comp_count),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub engine timing: cycles since eig_start rose, and which component it is serving
    always @(posedge clk) begin
        stub_cnt <= eig_start ? stub_cnt + 1 : 0;
        start_d  <= eig_start;
        if (!busy) begin
            stub_k <= 0;
        end else if (start_d && !eig_start) begin
            stub_k <= stub_k + 1;
        end
    end

    // Stub engine results: value k+1.0, unit vector e_k, input matrix halved
    always_comb begin
        eig_valid = eig_start && (stub_delay >= 0) && (stub_cnt >= stub_delay);
        eig_value[0][0] = $realtobits(real'(stub_k) + 1.0);
        for (int i = 0; i < N; i++) begin
            eig_vector[i][0] = (i == stub_k) ? $realtobits(1.0) : 64'd0;
            for (int j = 0; j < N; j++) begin
                eig_matrix_out[i][j] = $realtobits($bitstoreal(eig_matrix[i][j]) * 0.5);
            end
        end
    end

    task automatic check_bits(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: event not expected / bound expired", name);
    endtask

    task automatic check_all_zero(input string tag);
        check_bits({tag, "_eig_start"}, eig_start, 0);
        check_bits({tag, "_busy"}, busy, 0);
        check_bits({tag, "_done"}, done, 0);
        check_bits({tag, "_timeout_err"}, timeout_err, 0);
        check_bits({tag, "_comp_count"}, comp_count, 0);
        for (int k = 0; k < NC; k++) begin
            check_bits($sformatf("%s_eigval%0d", tag, k), eigenvalues[k], 0);
        end
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < NC; k++) begin
                check_bits($sformatf("%s_eigvec%0d_%0d", tag, i, k), eigenvectors[i][k], 0);
            end
            for (int j = 0; j < N; j++) begin
                check_bits($sformatf("%s_matrix%0d_%0d", tag, i, j), eig_matrix[i][j], 0);
            end
        end
    endtask

    // Builds the expected runs and result from the rules, then issues start
    task automatic apply_stimulus(input int delay);
        mat_t cov;
        run_t r;
        res_t e;
        real  scale;
        bit   ok_run;
        int   nruns;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                cov[i][j] = $realtobits(real'($urandom_range(0, 200000)) - 100000.0);
            end
        end
        ok_run = (delay >= 0) && (delay < TO);
        nruns  = ok_run ? NC : 1;
        scale  = 1.0;
        for (int ri = 0; ri < nruns; ri++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    r.mat[i][j] = $realtobits($bitstoreal(cov[i][j]) * scale);
                end
            end
            r.len = ok_run ? delay + 2 : TO;
            mat_q.push_back(r);
            scale = scale * 0.5;
        end
        e.count = ok_run ? NC : 0;
        e.terr  = !ok_run;
        e.vals  = '0;
        e.vecs  = '0;
        if (ok_run) begin
            for (int k = 0; k < NC; k++) begin
                e.vals[k]    = $realtobits(real'(k) + 1.0);
                e.vecs[k][k] = $realtobits(1.0);
            end
        end
        exp_q.push_back(e);
        last_count = e.count;
        stub_delay = delay;
        @(negedge clk);
        cov_matrix = cov;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_bits("start_latency", eig_start, 1);
        check_bits("busy_after_start", busy, 1);
    endtask

    // Waits for the monitor to drain the scoreboard, then checks IDLE holding
    task automatic check_output(input int budget);
        int b;
        b = budget;
        while (exp_q.size() > 0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (exp_q.size() > 0) begin
            fail_now("done_timeout");
            exp_q.delete();
            mat_q.delete();
        end
        repeat (3) @(negedge clk);
        check_bits("hold_comp_count", comp_count, last_count);
        check_bits("idle_busy", busy, 0);
    endtask

    task automatic wait_component(input int k);
        int b;
        b = 1000;
        while (!(stub_k == k && eig_start) && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (b == 0) begin
            fail_now($sformatf("wait_component%0d", k));
        end
    endtask

    // Monitor: checks each engine run and each done pulse against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev_es   = 0;
                mon_prev_done = 0;
                mon_gap_act   = 0;
                mon_cur_ok    = 0;
                mon_hi_len    = 0;
                continue;
            end
            if (eig_start && !mon_prev_es) begin
                if (mon_gap_act) begin
                    check_bits("gap_len", 64'(mon_gap_cnt), 2);
                end
                mon_gap_act = 0;
                if (mat_q.size() == 0) begin
                    fail_now("unexpected_run");
                end else begin
                    mon_cur    = mat_q.pop_front();
                    mon_cur_ok = 1;
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            check_bits($sformatf("eig_matrix%0d_%0d", i, j),
                                       eig_matrix[i][j], mon_cur.mat[i][j]);
                        end
                    end
                end
                mon_hi_len = 1;
            end else if (eig_start) begin
                mon_hi_len++;
            end else if (mon_prev_es) begin
                if (mon_cur_ok) begin
                    check_bits("run_len", 64'(mon_hi_len), 64'(mon_cur.len));
                end
                mon_cur_ok  = 0;
                mon_gap_act = busy;
                mon_gap_cnt = 1;
            end else if (busy) begin
                mon_gap_cnt++;
            end else begin
                mon_gap_act = 0;
            end
            if (done) begin
                check_bits("done_single", mon_prev_done, 0);
                check_bits("busy_at_done", busy, 1);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    mon_res = exp_q.pop_front();
                    check_bits("comp_count", comp_count, 64'(mon_res.count));
                    check_bits("timeout_err", timeout_err, mon_res.terr);
                    for (int k = 0; k < NC; k++) begin
                        check_bits($sformatf("eigval%0d", k), eigenvalues[k], mon_res.vals[k]);
                        for (int i = 0; i < N; i++) begin
                            check_bits($sformatf("eigvec%0d_%0d", i, k),
                                       eigenvectors[i][k], mon_res.vecs[i][k]);
                        end
                    end
                end
            end
            mon_prev_es   = eig_start;
            mon_prev_done = done;
        end
    end

    // Hard stop if something hangs outside the bounded waits
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] global timeout");
    end

    // Scenario sequence
    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cov_matrix = '0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] nominal 4-component run, engine delay 10");
        apply_stimulus(10);
        check_output(2000);

        $display("[TB] start pulsed while busy during component 2");
        apply_stimulus(int'($urandom_range(5, 20)));
        wait_component(1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output(2000);

        $display("[TB] engine never valid, watchdog timeout");
        apply_stimulus(-1);
        check_output(2000);

        $display("[TB] valid on exact watchdog-expiry cycle");
        apply_stimulus(TO - 1);
        check_output(2000);

        $display("[TB] reset during third run");
        apply_stimulus(10);
        wait_component(2);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrun_reset");
        mat_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_bits("wait_after_reset", busy, 0);
        apply_stimulus(10);
        check_output(2000);

        $display("[TB] random engine delays");
        for (int n = 0; n < 3; n++) begin
            apply_stimulus(int'($urandom_range(0, TO - 1)));
            check_output(2000);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
